// File: rtl/pci_rr_arbiter.sv
// Central PCI bus arbiter: rotating round-robin grants, withdrawal only at legal bus points,
// and reclaim of unused grants. Define PCI_ARB_PARK_EN to park the idle bus on the last master.
module pci_rr_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int GNT_TIMEOUT = 16,
    localparam int IDX_W = $clog2(NUM_MASTERS)
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic                   frame_i,
    input  logic                   irdy_i,
    output logic [NUM_MASTERS-1:0] gnt_o,
    output logic [IDX_W-1:0]       gnt_idx_o,
    output logic                   gnt_valid_o,
    output logic                   bus_busy_o,
    output logic                   timeout_pulse_o
);

    // state | meaning
    // IDLE  | no grant issued (or bus parked); evaluating requests
    // GRANT | one master granted, waiting for it to start a frame
    // BUSY  | transaction in progress, all grants high
    // TURN  | one turnaround cycle with all grants high
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;
    localparam logic [1:0] ST_TURN  = 2'd3;

    localparam int TMO_W = $clog2(GNT_TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(GNT_TIMEOUT - 1);

    logic [1:0]             state_q, state_d;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]       gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic [IDX_W-1:0]       winner;
    logic                   any_req;
    logic                   timeout_hit;

    assign any_req = ~&req_i;

    // Search begins one past the last winner and wraps, so the previous owner ranks lowest.
    always_comb begin : rr_search
        logic             found;
        logic [IDX_W-1:0] cand;
        winner = last_q;
        found  = 1'b0;
        cand   = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            if ((int'(last_q) + i) >= NUM_MASTERS) begin
                cand = IDX_W'(int'(last_q) + i - NUM_MASTERS);
            end else begin
                cand = IDX_W'(int'(last_q) + i);
            end
            if (!found && !req_i[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

`ifdef PCI_ARB_PARK_EN
    logic parked;
    assign parked = (state_q == ST_IDLE) && (gnt_q != '1);
`endif

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        last_d      = last_q;
        tmo_cnt_d   = tmo_cnt_q;
        timeout_hit = 1'b0;
        case (state_q)
            ST_IDLE: begin
`ifdef PCI_ARB_PARK_EN
                if (parked) begin
                    if (!frame_i) begin
                        state_d = ST_BUSY;
                        gnt_d   = '1;
                    end else if (any_req) begin
                        state_d = ST_TURN;
                        gnt_d   = '1;
                    end
                end else if (any_req) begin
                    state_d        = ST_GRANT;
                    gnt_d          = '1;
                    gnt_d[winner]  = 1'b0;
                    gnt_idx_d      = winner;
                    last_d         = winner;
                    tmo_cnt_d      = '0;
                end else begin
                    gnt_d         = '1;
                    gnt_d[last_q] = 1'b0;
                    gnt_idx_d     = last_q;
                end
`else
                gnt_d = '1;
                if (any_req) begin
                    state_d        = ST_GRANT;
                    gnt_d[winner]  = 1'b0;
                    gnt_idx_d      = winner;
                    last_d         = winner;
                    tmo_cnt_d      = '0;
                end
`endif
            end
            ST_GRANT: begin
                if (!frame_i) begin
                    state_d = ST_BUSY;
                    gnt_d   = '1;
                end else if (req_i[gnt_idx_q]) begin
                    state_d = ST_TURN;
                    gnt_d   = '1;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d     = ST_TURN;
                    gnt_d       = '1;
                    timeout_hit = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            ST_BUSY: begin
                gnt_d = '1;
                if (frame_i && irdy_i) begin
                    state_d = ST_TURN;
                end
            end
            ST_TURN: begin
                gnt_d   = '1;
                state_d = ST_IDLE;
            end
            default: begin
                gnt_d   = '1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '1;
            gnt_idx_q <= '0;
            last_q    <= IDX_W'(NUM_MASTERS - 1);
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            last_q    <= last_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign gnt_o           = gnt_q;
    assign gnt_idx_o       = gnt_idx_q;
    assign gnt_valid_o     = ~&gnt_q;
    assign bus_busy_o      = (state_q == ST_BUSY);
    assign timeout_pulse_o = timeout_hit;

endmodule

// File: tb/tb_pci_rr_arbiter.sv
// Bench for pci_rr_arbiter: grants predicted by a round-robin reference model and checked by a
// scoreboard monitor; bus-phase timing checked inline by the stimulus process.
module tb_pci_rr_arbiter;
    localparam int N   = 4;
    localparam int TMO = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req;
    logic         frame;
    logic         irdy;
    logic [N-1:0] gnt;
    logic [1:0]   gnt_idx;
    logic         gnt_valid;
    logic         bus_busy;
    logic         timeout_pulse;

    int tests = 0;
    int fails = 0;
    int model_last = N - 1;

    logic [N-1:0] sb_gnt[$];
    int           sb_idx[$];
    logic [N-1:0] all_high;

    pci_rr_arbiter #(.NUM_MASTERS(N), .GNT_TIMEOUT(TMO)) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .req_i          (req),
        .frame_i        (frame),
        .irdy_i         (irdy),
        .gnt_o          (gnt),
        .gnt_idx_o      (gnt_idx),
        .gnt_valid_o    (gnt_valid),
        .bus_busy_o     (bus_busy),
        .timeout_pulse_o(timeout_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: first requesting master at or after (last+1) mod N.
    function automatic int rr_pick(input logic [N-1:0] mask);
        int  w;
        bit  found;
        w = -1;
        found = 0;
        for (int i = 1; i <= N; i++) begin
            int c;
            c = (model_last + i) % N;
            if (!found && mask[c]) begin
                w = c;
                found = 1;
            end
        end
        return w;
    endfunction

    // kind 0: transaction after d grant cycles; 1: withdrawal after d cycles; 2: timeout
    task automatic episode(input logic [N-1:0] mask, input int kind, input int d);
        int           w;
        logic [N-1:0] eg;
        w = rr_pick(mask);
        eg = all_high;
        eg[w] = 1'b0;
        sb_gnt.push_back(eg);
        sb_idx.push_back(w);
        model_last = w;
        req = ~mask;
        tick();
        check("grant_latency", gnt, eg);
        case (kind)
            0: begin
                repeat (d) begin
                    tick();
                    check("grant_held", gnt, eg);
                end
                frame = 1'b0;
                irdy  = 1'b0;
                tick();
                check("busy_gnt_high", gnt, all_high);
                check("busy_flag", bus_busy, 1);
                frame = 1'b1;
                if (d % 2 == 1) begin
                    tick();
                    check("busy_while_irdy_low", bus_busy, 1);
                end
                irdy = 1'b1;
                tick();
                check("turn_not_busy", bus_busy, 0);
                check("turn_gnt_high", gnt, all_high);
            end
            1: begin
                repeat (d) begin
                    tick();
                    check("grant_held", gnt, eg);
                end
                req[w] = 1'b1;
                tick();
                check("withdraw_gnt_high", gnt, all_high);
                check("withdraw_no_pulse", timeout_pulse, 0);
            end
            default: begin
                for (int c = 1; c < TMO; c++) begin
                    check("no_early_timeout", timeout_pulse, 0);
                    tick();
                end
                check("timeout_pulse", timeout_pulse, 1);
                check("timeout_gnt_still_low", gnt, eg);
                tick();
                check("timeout_gnt_high", gnt, all_high);
                check("timeout_pulse_1cyc", timeout_pulse, 0);
            end
        endcase
        tick();
        check("idle_gnt_high", gnt, all_high);
        check("idle_not_valid", gnt_valid, 0);
    endtask

    // Scoreboard monitor: each fresh grant must match the oldest predicted grant.
    initial begin
        logic         prev_valid;
        logic [N-1:0] prev_gnt;
        logic [N-1:0] eg;
        int           ei;
        prev_valid = 1'b0;
        prev_gnt   = '1;
        forever begin
            @(negedge clk);
            if (gnt_valid === 1'b1 && prev_valid !== 1'b1) begin
                if (sb_gnt.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_unexpected_grant: got gnt=%b expected none", gnt);
                end else begin
                    eg = sb_gnt.pop_front();
                    ei = sb_idx.pop_front();
                    check("sb_gnt", gnt, eg);
                    check("sb_gnt_idx", gnt_idx, ei);
                end
            end else if (gnt_valid === 1'b1 && prev_valid === 1'b1) begin
                check("no_switch_while_granted", gnt, prev_gnt);
            end
            prev_valid = gnt_valid;
            prev_gnt   = gnt;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        all_high = '1;
        reset = 1'b1;
        req   = '1;
        frame = 1'b1;
        irdy  = 1'b1;
        tick();
        tick();
        check("rst_gnt", gnt, all_high);
        check("rst_idx", gnt_idx, 0);
        check("rst_valid", gnt_valid, 0);
        check("rst_busy", bus_busy, 0);
        check("rst_pulse", timeout_pulse, 0);
        reset = 1'b0;
        tick();
        check("idle_no_req", gnt, all_high);

        // All masters requesting continuously: order 0,1,2,3,0.
        repeat (5) episode(4'b1111, 0, 0);
        // Single master never starts a frame; re-granted afterwards.
        episode(4'b0010, 2, 0);
        episode(4'b0010, 0, 1);
        // Withdrawal with master 2 pending.
        episode(4'b1000, 0, 0);
        episode(4'b0101, 1, 0);
        episode(4'b0100, 0, 0);

        // Reset while BUSY.
        sb_gnt.push_back(4'b1110);
        sb_idx.push_back(0);
        model_last = 0;
        req = 4'b1110;
        tick();
        frame = 1'b0;
        irdy  = 1'b0;
        tick();
        check("busy_before_reset", bus_busy, 1);
        reset = 1'b1;
        req   = '1;
        tick();
        check("midrst_gnt", gnt, all_high);
        check("midrst_busy", bus_busy, 0);
        check("midrst_idx", gnt_idx, 0);
        reset = 1'b0;
        model_last = N - 1;
        tick();
        check("frame_ignored_idle", gnt, all_high);
        check("frame_ignored_busy", bus_busy, 0);
        frame = 1'b1;
        irdy  = 1'b1;
        episode(4'b1111, 0, 0);

        for (int e = 0; e < 40; e++) begin
            logic [N-1:0] m;
            int           k;
            int           kind;
            m = N'($urandom_range(1, (1 << N) - 1));
            k = $urandom_range(0, 9);
            kind = (k < 5) ? 0 : ((k < 8) ? 1 : 2);
            episode(m, kind, $urandom_range(0, 4));
        end

        req = '1;
        tick();
        tick();
        check("sb_drained", sb_gnt.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
